// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer and imem.
// master: drives imem_req/imem_addr; slave: returns imem_ack/imem_rdata.
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch controller: owns the PC, picks trap/branch/jump/sequential next PC,
// runs the imem req/ack handshake and buffers one instruction for decode.
// Ports: clk, rst (async high), imem (master modport), stall, br_taken,
// br_target, jmp, jmp_target, trap, trap_vec, inst_valid, inst, inst_pc,
// pc, fetch_err.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pc_sequencer_if.master        imem,
    input  logic                  stall,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    input  logic                  jmp,
    input  logic [31:0]           jmp_target,
    input  logic                  trap,
    input  logic [31:0]           trap_vec,
    output logic                  inst_valid,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc,
    output logic [31:0]           pc,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Counter value at which the next unacked request cycle trips the timeout.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] ipc_q, ipc_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;

    logic        redirect;
    logic [31:0] target;
    logic        req;
    logic        accept;

    // Fixed priority: trap > branch > jump.
    always_comb begin
        if (trap) begin
            target = trap_vec;
        end else if (br_taken) begin
            target = br_target;
        end else begin
            target = jmp_target;
        end
    end

    assign redirect = trap | br_taken | jmp;

    // Request is withheld while a redirect is pending (the ack would be
    // for the wrong path) and while a stalled instruction is held.
    assign req = (state_q == FETCH) && !redirect
              && (!valid_q || !stall);
    assign accept = req && imem.imem_ack;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        err_d   = err_q;
        wait_d  = wait_q;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pc_d    = target & ~32'h3;
                    valid_d = 1'b0;
                    wait_d  = 8'd0;
                end else if (accept) begin
                    inst_d  = imem.imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    wait_d  = 8'd0;
                end else begin
                    if (valid_q && !stall) begin
                        valid_d = 1'b0;
                    end
                    if (req) begin
                        if (wait_q == WAIT_LAST) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                            wait_d  = 8'd0;
                        end else begin
                            wait_d = wait_q + 8'd1;
                        end
                    end
                end
            end
            ERR: begin
                valid_d = 1'b0;
                if (trap) begin
                    state_d = FETCH;
                    pc_d    = trap_vec & ~32'h3;
                    err_d   = 1'b0;
                    wait_d  = 8'd0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
            ipc_q   <= 32'd0;
            err_q   <= 1'b0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = ipc_q;
    assign pc         = pc_q;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus async-reset sequences.
// Memory model returns addr ^ A5A5A5A5 whenever ack is enabled.
module tb_pc_sequencer;

    localparam logic [31:0] XK = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        trap;
    logic [31:0] trap_vec;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;
    logic        fetch_err;
    logic        ack_en;

    int checks;
    int errors;

    pc_sequencer_if ifc ();

    assign ifc.imem_ack   = ack_en;
    assign ifc.imem_rdata = ifc.imem_addr ^ XK;

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (ifc.master),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .trap       (trap),
        .trap_vec   (trap_vec),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        trap;
        logic [31:0] tv;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic s, input logic a,
        input logic t, input logic [31:0] tv,
        input logic b, input logic [31:0] bt,
        input logic j, input logic [31:0] jt,
        input logic rq, input logic vl,
        input logic [31:0] ipc, input logic [31:0] p,
        input logic er
    );
        vec_t v;
        v.stall = s;   v.ack = a;
        v.trap = t;    v.tv = tv;
        v.br = b;      v.bt = bt;
        v.jmp = j;     v.jt = jt;
        v.e_req = rq;  v.e_valid = vl;
        v.e_ipc = ipc; v.e_pc = p;
        v.e_err = er;
        return v;
    endfunction

    task automatic chk(
        input string name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; br_taken = 0; jmp = 0; trap = 0;
        br_target = 0; jmp_target = 0; trap_vec = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ack_en = 1'b0;
        idle_inputs();

        // s a  t tv      b bt      j jt            req v ipc          pc           err
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            0,0,0,           0,           0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,0,0,           0,           0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,1,0,           4,           0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,1,4,           8,           0));
        vecs.push_back(mk(1,1, 0,0,      0,0,      0,0,            0,1,8,           32'hC,       0));
        vecs.push_back(mk(1,1, 0,0,      0,0,      0,0,            0,1,8,           32'hC,       0));
        vecs.push_back(mk(1,1, 0,0,      0,0,      0,0,            0,1,8,           32'hC,       0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,1,8,           32'hC,       0));
        vecs.push_back(mk(0,1, 1,32'h100,1,32'h200,1,32'h300,      0,1,32'hC,       32'h10,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,0,32'hC,       32'h100,     0));
        vecs.push_back(mk(0,1, 0,0,      1,32'h203,0,0,            0,0,32'hC,       32'h100,     0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,0,32'hC,       32'h200,     0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      1,32'h40,       0,1,32'h200,     32'h204,     0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,0,32'h200,     32'h40,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,0,32'h200,     32'h40,      0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,0,32'h200,     32'h40,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,1,32'h40,      32'h44,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,0,32'h40,      32'h44,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,0,32'h40,      32'h44,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      0,0,            1,0,32'h40,      32'h44,      0));
        vecs.push_back(mk(0,0, 0,0,      0,0,      1,32'h300,      0,0,32'h40,      32'h44,      1));
        vecs.push_back(mk(0,0, 1,32'h80, 0,0,      0,0,            0,0,32'h40,      32'h44,      1));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,0,32'h40,      32'h80,      0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      1,32'hFFFF_FFFC,0,1,32'h80,      32'h84,      0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,0,32'h80,      32'hFFFF_FFFC,0));
        vecs.push_back(mk(0,1, 0,0,      0,0,      0,0,            1,1,32'hFFFF_FFFC,32'h0,      0));

        #12;
        chk("rst_pc",    pc,           32'h0);
        chk("rst_req",   ifc.imem_req, 1'b0);
        chk("rst_valid", inst_valid,   1'b0);
        chk("rst_inst",  inst,         32'h0);
        chk("rst_ipc",   inst_pc,      32'h0);
        chk("rst_err",   fetch_err,    1'b0);

        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall      = vecs[i].stall;
            ack_en     = vecs[i].ack;
            trap       = vecs[i].trap;
            trap_vec   = vecs[i].tv;
            br_taken   = vecs[i].br;
            br_target  = vecs[i].bt;
            jmp        = vecs[i].jmp;
            jmp_target = vecs[i].jt;
            #1;
            chk($sformatf("v%0d_req", i), ifc.imem_req, vecs[i].e_req);
            chk($sformatf("v%0d_valid", i), inst_valid, vecs[i].e_valid);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_addr", i), ifc.imem_addr, vecs[i].e_pc);
            chk($sformatf("v%0d_err", i), fetch_err, vecs[i].e_err);
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_ipc", i), inst_pc, vecs[i].e_ipc);
                chk($sformatf("v%0d_inst", i), inst, vecs[i].e_ipc ^ XK);
            end
            @(posedge clk);
            #1;
        end

        // Wrapped PC with a valid instruction (addr 0) held; reset mid-cycle.
        idle_inputs();
        ack_en = 1'b0;
        chk("pre_rst_pc",    pc,         32'h4);
        chk("pre_rst_valid", inst_valid, 1'b1);
        chk("pre_rst_inst",  inst,       32'h0 ^ XK);
        #2 rst = 1'b1;
        #1;
        chk("arst_pc",    pc,           32'h0);
        chk("arst_valid", inst_valid,   1'b0);
        chk("arst_req",   ifc.imem_req, 1'b0);
        chk("arst_inst",  inst,         32'h0);
        chk("arst_ipc",   inst_pc,      32'h0);

        // Time out from reset, then reset again while the error is set.
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        begin
            int n;
            n = 0;
            while (!fetch_err && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("to_err",    fetch_err,    1'b1);
            chk("to_cycles", n,            4);
            chk("to_req",    ifc.imem_req, 1'b0);
            chk("to_pc",     pc,           32'h0);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst2_err", fetch_err,    1'b0);
        chk("arst2_req", ifc.imem_req, 1'b0);
        #5 rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
